// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and register-file constants.
// Includes a helper that recognises a load-use dependency between the EX and ID stages.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ABORT    = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // $zero is never a real producer, so a load targeting it cannot create a hazard
   function automatic logic load_use_hit(
      input logic       ex_mem_read,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       id_uses_rt
   );
      return ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of hazard inputs and stage enable/flush controls between the pipeline and the controller.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_controller_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       i_id_rs;
   logic [4:0]       i_id_rt;
   logic             i_id_uses_rt;
   logic [4:0]       i_ex_rt;
   logic             i_ex_mem_read;
   logic             i_id_branch_taken;
   logic             i_id_jump;
   logic             i_mem_req;
   logic             i_mem_ready;
   logic             o_pc_write;
   logic             o_if_id_write;
   logic             o_if_id_flush;
   logic             o_id_ex_write;
   logic             o_id_ex_flush;
   logic             o_ex_mem_write;
   logic             o_ex_mem_flush;
   logic             o_mem_wb_flush;
   logic             o_mem_timeout;
   logic [CNT_W-1:0] o_stall_count;
   logic [CNT_W-1:0] o_flush_count;

   modport master (
      output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rt, i_ex_mem_read,
             i_id_branch_taken, i_id_jump, i_mem_req, i_mem_ready,
      input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write, o_id_ex_flush,
             o_ex_mem_write, o_ex_mem_flush, o_mem_wb_flush, o_mem_timeout,
             o_stall_count, o_flush_count
   );

   modport slave (
      input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rt, i_ex_mem_read,
             i_id_branch_taken, i_id_jump, i_mem_req, i_mem_ready,
      output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write, o_id_ex_flush,
             o_ex_mem_write, o_ex_mem_flush, o_mem_wb_flush, o_mem_timeout,
             o_stall_count, o_flush_count
   );

endinterface

// File: rtl/pipeline_hazard_controller_perf_sat_counter.sv
// Saturating event counter: count is registered, updates one cycle after inc, holds at all-ones.
// Synchronous active-low reset clears it; no backpressure.
module perf_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: controls are combinational (same-cycle),
// state, timeout flag and counters registered; memory waits freeze the pipe until ready or timeout.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8,
   parameter int CNT_W       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   pipeline_hazard_controller_if.slave hz
);

   state_e            state_q, state_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [TO_W-1:0]   wait_next;
   logic              load_use;
   logic              mem_miss;

   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic ex_mem_write, ex_mem_flush, mem_wb_flush;
   logic [CNT_W-1:0] stall_count, flush_count;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      load_use = load_use_hit(hz.i_ex_mem_read, hz.i_ex_rt, hz.i_id_rs,
                              hz.i_id_rt, hz.i_id_uses_rt);
      mem_miss = hz.i_mem_req && !hz.i_mem_ready;
      // wait_next is the number of frozen cycles including this one
      wait_next = ((state_q == MEM_WAIT) ? wait_cnt_q : '0) + TO_W'(1);

      case (state_q)
         RUN, MEM_WAIT: begin
            if ((state_q == RUN) ? mem_miss : !hz.i_mem_ready) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_write = 1'b0;
               mem_wb_flush = 1'b1;
               if (wait_next == TO_W'(MEM_TIMEOUT)) begin
                  state_d    = ABORT;
                  wait_cnt_d = '0;
                  timeout_d  = 1'b1;
               end else begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = wait_next;
               end
            end else if (state_q == MEM_WAIT) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end else if (hz.i_id_branch_taken || hz.i_id_jump) begin
               if_id_flush = 1'b1;
            end
         end
         ABORT: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
            wait_cnt_d   = '0;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!pc_write),
      .count (stall_count)
   );

   perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_count)
   );

   assign hz.o_pc_write     = pc_write;
   assign hz.o_if_id_write  = if_id_write;
   assign hz.o_if_id_flush  = if_id_flush;
   assign hz.o_id_ex_write  = id_ex_write;
   assign hz.o_id_ex_flush  = id_ex_flush;
   assign hz.o_ex_mem_write = ex_mem_write;
   assign hz.o_ex_mem_flush = ex_mem_flush;
   assign hz.o_mem_wb_flush = mem_wb_flush;
   assign hz.o_mem_timeout  = timeout_q;
   assign hz.o_stall_count  = stall_count;
   assign hz.o_flush_count  = flush_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random traffic against a rule-level model.
module tb_pipeline_hazard_controller;
   import pipeline_ctrl_pkg::*;

   localparam int TO = 4;
   localparam int CW = 32;

   // control vector: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f}
   localparam logic [7:0] C_DEFAULT = 8'b1101_0100;
   localparam logic [7:0] C_FORCED  = 8'b0010_1011;
   localparam logic [7:0] C_FREEZE  = 8'b0000_0001;
   localparam logic [7:0] C_LOADUSE = 8'b0001_1100;
   localparam logic [7:0] C_BRANCH  = 8'b1111_0100;
   localparam logic [7:0] C_ABORT   = 8'b0001_0111;

   logic clk = 1'b0;
   logic reset;
   logic sc_inc;
   logic [2:0] sc_count;
   always #5 clk = ~clk;

   pipeline_hazard_controller_if #(.CNT_W(CW)) hif ();

   pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   perf_sat_counter #(.W(3)) u_sc (
      .clk   (clk),
      .reset (reset),
      .inc   (sc_inc),
      .count (sc_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: how many frozen cycles this access has taken, and whether the abort cycle is due
   int          m_frozen = 0;
   bit          m_abort  = 0;
   bit          m_to     = 0;
   logic [31:0] m_stall  = '0;
   logic [31:0] m_flush  = '0;

   function automatic logic [7:0] model_ctrl();
      bit lu;
      lu = hif.i_ex_mem_read && (hif.i_ex_rt != 5'd0) &&
           ((hif.i_ex_rt == hif.i_id_rs) || (hif.i_id_uses_rt && (hif.i_ex_rt == hif.i_id_rt)));
      if (!reset)                                return C_FORCED;
      if (m_abort)                               return C_ABORT;
      if (m_frozen > 0)                          return hif.i_mem_ready ? C_DEFAULT : C_FREEZE;
      if (hif.i_mem_req && !hif.i_mem_ready)     return C_FREEZE;
      if (lu)                                    return C_LOADUSE;
      if (hif.i_id_branch_taken || hif.i_id_jump) return C_BRANCH;
      return C_DEFAULT;
   endfunction

   task automatic model_update(input logic [7:0] e);
      if (!reset) begin
         m_frozen = 0; m_abort = 0; m_to = 0; m_stall = '0; m_flush = '0;
      end else begin
         if (!e[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (e[5] && m_flush != 32'hFFFF_FFFF)  m_flush = m_flush + 1;
         if (m_abort) begin
            m_abort = 0;
         end else if (e == C_FREEZE) begin
            m_frozen = m_frozen + 1;
            if (m_frozen == TO) begin
               m_abort = 1; m_to = 1; m_frozen = 0;
            end
         end else begin
            m_frozen = 0;
         end
      end
   endtask

   task automatic step(input string tag);
      logic [7:0] e, g;
      @(negedge clk);
      e = model_ctrl();
      g = {hif.o_pc_write, hif.o_if_id_write, hif.o_if_id_flush, hif.o_id_ex_write,
           hif.o_id_ex_flush, hif.o_ex_mem_write, hif.o_ex_mem_flush, hif.o_mem_wb_flush};
      n_cmp++;
      if (g !== e) begin
         n_bad++; $display("FAIL %s ctrl: got %b expected %b", tag, g, e);
      end
      n_cmp++;
      if (hif.o_mem_timeout !== m_to) begin
         n_bad++; $display("FAIL %s mem_timeout: got %b expected %b", tag, hif.o_mem_timeout, m_to);
      end
      n_cmp++;
      if (hif.o_stall_count !== m_stall) begin
         n_bad++; $display("FAIL %s stall_count: got %0d expected %0d", tag, hif.o_stall_count, m_stall);
      end
      n_cmp++;
      if (hif.o_flush_count !== m_flush) begin
         n_bad++; $display("FAIL %s flush_count: got %0d expected %0d", tag, hif.o_flush_count, m_flush);
      end
      model_update(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hif.i_id_rs = 5'd0; hif.i_id_rt = 5'd0; hif.i_id_uses_rt = 1'b0;
      hif.i_ex_rt = 5'd0; hif.i_ex_mem_read = 1'b0; hif.i_id_branch_taken = 1'b0;
      hif.i_id_jump = 1'b0; hif.i_mem_req = 1'b0; hif.i_mem_ready = 1'b0;
   endtask

   task automatic random_inputs(input int rmax);
      hif.i_id_rs = 5'($urandom_range(rmax)); hif.i_id_rt = 5'($urandom_range(rmax));
      hif.i_ex_rt = 5'($urandom_range(rmax));
      hif.i_id_uses_rt = 1'($urandom); hif.i_ex_mem_read = 1'($urandom);
      hif.i_id_branch_taken = 1'($urandom); hif.i_id_jump = ($urandom_range(3) == 0);
      hif.i_mem_req = ($urandom_range(3) == 0); hif.i_mem_ready = 1'($urandom);
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++; $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         random_inputs(31);
         step("reset_hold");
      end
      check_val("reset_stall_zero", hif.o_stall_count, 32'd0);
      reset = 1'b1;
      idle_inputs();
      step("reset_release");
   endtask

   task automatic test_load_use();
      logic [31:0] s0;
      idle_inputs();
      s0 = hif.o_stall_count;
      hif.i_ex_mem_read = 1'b1; hif.i_ex_rt = 5'd8; hif.i_id_rs = 5'd8;
      step("lu_rs_hit");
      check_val("lu_one_bubble", hif.o_stall_count, s0 + 1);
      hif.i_ex_mem_read = 1'b0;
      step("lu_load_advanced");
      hif.i_ex_mem_read = 1'b1; hif.i_ex_rt = 5'd0; hif.i_id_rs = 5'd0;
      step("lu_zero_reg");
      hif.i_ex_rt = 5'd5; hif.i_id_rs = 5'd1; hif.i_id_rt = 5'd5; hif.i_id_uses_rt = 1'b1;
      step("lu_rt_hit");
      hif.i_id_uses_rt = 1'b0;
      step("lu_rt_unused");
      idle_inputs();
   endtask

   task automatic test_branch();
      logic [31:0] f0;
      idle_inputs();
      f0 = hif.o_flush_count;
      hif.i_id_branch_taken = 1'b1;
      step("br_taken");
      check_val("br_flush_count", hif.o_flush_count, f0 + 1);
      hif.i_ex_mem_read = 1'b1; hif.i_ex_rt = 5'd9; hif.i_id_rs = 5'd9;
      step("br_with_lu");
      check_val("br_lu_no_flush", hif.o_flush_count, f0 + 1);
      idle_inputs(); hif.i_id_jump = 1'b1;
      step("jump");
      idle_inputs();
      step("br_idle");
   endtask

   task automatic test_mem_wait();
      logic [31:0] s0;
      idle_inputs();
      s0 = hif.o_stall_count;
      hif.i_mem_req = 1'b1; hif.i_id_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) step("mw_frozen");
      hif.i_mem_ready = 1'b1;
      step("mw_ready");
      check_val("mw_stall_delta", hif.o_stall_count, s0 + 3);
      idle_inputs();
      step("mw_after");
   endtask

   task automatic test_timeout();
      idle_inputs();
      hif.i_mem_req = 1'b1;
      for (int i = 0; i < TO; i++) step("to_frozen");
      hif.i_mem_ready = 1'b1;
      step("to_abort");
      idle_inputs();
      for (int i = 0; i < 3; i++) step("to_after");
      check_val("to_sticky", 32'(hif.o_mem_timeout), 32'd1);
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      hif.i_mem_req = 1'b1;
      step("rmw_wait0");
      step("rmw_wait1");
      reset = 1'b0;
      step("rmw_reset");
      reset = 1'b1;
      idle_inputs();
      step("rmw_release");
      check_val("rmw_timeout_clr", 32'(hif.o_mem_timeout), 32'd0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(99) != 0);
         random_inputs(3);
         step("random");
      end
      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 6; i++) step("random_drain");
   endtask

   task automatic test_sat_counter();
      idle_inputs();
      reset = 1'b0;
      step("sat_reset");
      reset = 1'b1;
      sc_inc = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step("sat_run");
         check_val("sat_count", 32'(sc_count), (k > 7) ? 32'd7 : 32'(k));
      end
      sc_inc = 1'b0;
      step("sat_hold");
      check_val("sat_hold", 32'(sc_count), 32'd7);
   endtask

   initial begin
      reset  = 1'b0;
      sc_inc = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      test_sat_counter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branch/jump redirects and multi-cycle data-memory waits.
- Supervises the memory wait with a timeout and keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before abort (1..2^TO_W-1)
- TO_W, 8, width of wait/timeout counter
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- i_id_rs  in  5  rs of instruction in ID
- i_id_rt  in  5  rt of instruction in ID
- i_id_uses_rt  in  1  ID instruction reads rt
- i_ex_rt  in  5  load destination of instruction in EX
- i_ex_mem_read  in  1  EX instruction is a load
- i_id_branch_taken  in  1  branch in ID resolved taken
- i_id_jump  in  1  jump/jr/jal in ID
- i_mem_req  in  1  MEM-stage instruction accesses data memory
- i_mem_ready  in  1  data memory completes this cycle
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID clear to NOP
- o_id_ex_write  out  1  ID/EX load enable
- o_id_ex_flush  out  1  ID/EX clear (bubble)
- o_ex_mem_write  out  1  EX/MEM load enable
- o_ex_mem_flush  out  1  EX/MEM clear
- o_mem_wb_flush  out  1  MEM/WB loads bubble (reg_write=0, mem_to_reg=0)
- o_mem_timeout  out  1  sticky: a memory access was aborted
- o_stall_count  out  CNT_W  cycles with o_pc_write=0
- o_flush_count  out  CNT_W  cycles with o_if_id_flush=1

Behaviour:
- Control outputs are combinational from state and inputs (same-cycle effect); counters, state, o_mem_timeout are registered.
- reset=0 at an edge: state<=RUN, wait counter<=0, counters<=0, o_mem_timeout<=0. While reset=0, control outputs forced: all writes 0, all flushes 1.
- Defaults (no event): all writes 1, all flushes 0.
- FSM states RUN, MEM_WAIT, ABORT.
- RUN, i_mem_req=1 & i_mem_ready=0: freeze (pc/if_id/id_ex/ex_mem writes 0), o_mem_wb_flush=1; next MEM_WAIT, wait counter<=1. Load-use and branch effects are suppressed this cycle.
- RUN, load-use: i_ex_mem_read & i_ex_rt!=0 & (i_ex_rt==i_id_rs | (i_id_uses_rt & i_ex_rt==i_id_rt)).
  - Response: o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1; branch/jump flush suppressed.
  - Exactly one bubble per hazard, since the load advances.
- RUN, no stall, i_id_branch_taken|i_id_jump: o_if_id_flush=1 for one cycle.
- Priority: memory wait > load-use > branch/jump.
- MEM_WAIT, i_mem_ready=0:
  - Same freeze plus o_mem_wb_flush=1; wait counter increments.
  - When counter==MEM_TIMEOUT: next ABORT, o_mem_timeout<=1.
- MEM_WAIT, i_mem_ready=1: defaults apply (pipeline advances, MEM/WB captures data); next RUN; counter<=0.
- ABORT (one cycle):
  - o_pc_write=0, o_if_id_write=0, o_ex_mem_flush=1, o_mem_wb_flush=1.
  - Next RUN. i_mem_ready is ignored in this state.
- o_mem_timeout clears only on reset.
- Counters saturate at 2^CNT_W-1; increment only while reset=1.

Decomposition:
- Package pipeline_ctrl_pkg holds the FSM state encoding (RUN=0, MEM_WAIT=1, ABORT=2, 2 bits) and REG_ZERO=5'd0.
- One sub-module, perf_sat_counter (param W, inputs clk/reset/inc, output count), instantiated twice.

Test Plan:
- Reset held 3 cycles with activity on all inputs -> writes 0, flushes 1, counters 0; release -> defaults, o_mem_timeout=0.
- Load-use: i_ex_mem_read=1, i_ex_rt=8, i_id_rs=8 -> one cycle pc_write=0/if_id_write=0/id_ex_flush=1, stall_count=1. Repeat with i_ex_rt=0 -> no stall.
- Branch taken in ID, no hazard -> if_id_flush=1 for 1 cycle, flush_count=1. Branch together with load-use -> stall only, flush_count unchanged.
- Memory wait, i_mem_ready low 3 cycles then high -> 3 frozen cycles with mem_wb_flush=1, advance on 4th, stall_count+=3.
- MEM_TIMEOUT=4, ready never asserted -> ABORT on cycle 5 (ex_mem_flush=1, mem_wb_flush=1), o_mem_timeout=1 sticky, back to RUN.
- Reset asserted mid MEM_WAIT -> next cycle state RUN, counters and timeout flag 0.
